// File: rtl/clock_shield_pkg.sv
// Shared types for the clock-shield button path: event classes and per-button press states.
package clock_shield_pkg;

  typedef enum logic [1:0] {
    EV_SHORT  = 2'd0,
    EV_LONG   = 2'd1,
    EV_REPEAT = 2'd2
  } ev_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StAuto
  } btn_state_e;

endpackage

// File: rtl/button_event_arbiter_if.sv
// Valid/ready event stream from the button arbiter to the time-setting FSM.
interface button_event_arbiter_if #(
  parameter int unsigned N_BTN = 4
) ();
  localparam int unsigned IdxW = $clog2(N_BTN);

  logic            ev_valid;
  logic            ev_ready;
  logic [IdxW-1:0] ev_btn;
  logic [1:0]      ev_type;

  modport master (output ev_valid, output ev_btn, output ev_type, input ev_ready);
  modport slave  (input ev_valid, input ev_btn, input ev_type, output ev_ready);
endinterface

// File: rtl/button_event_arbiter_press_timer.sv
// Per-button hold classifier: turns down/up pulses plus ms ticks into SHORT/LONG/REPEAT strobes.
module press_timer
  import clock_shield_pkg::*;
#(
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tick,
  input  logic     down,
  input  logic     up,
  output logic     held,
  output logic     ev_strobe,
  output ev_type_e ev_type
);
  localparam int unsigned CntMax = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] LongLast = CntW'(LONG_MS - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_MS - 1);

  btn_state_e      state_q;
  logic [CntW-1:0] cnt_q;

  // Strobe is combinational so the pending slot captures it at the end of the cause cycle.
  always_comb begin
    ev_strobe = 1'b0;
    ev_type   = EV_SHORT;
    case (state_q)
      StHeld: begin
        if (up) begin
          ev_strobe = 1'b1;
          ev_type   = EV_SHORT;
        end else if (tick && cnt_q == LongLast) begin
          ev_strobe = 1'b1;
          ev_type   = EV_LONG;
        end
      end
      StAuto: begin
        if (!up && tick && cnt_q == RepLast) begin
          ev_strobe = 1'b1;
          ev_type   = EV_REPEAT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      held    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (down && !up) begin
            state_q <= StHeld;
            cnt_q   <= '0;
            held    <= 1'b1;
          end
        end
        StHeld: begin
          if (up) begin
            state_q <= StIdle;
            held    <= 1'b0;
          end else if (tick) begin
            if (cnt_q == LongLast) begin
              state_q <= StAuto;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StAuto: begin
          if (up) begin
            state_q <= StIdle;
            held    <= 1'b0;
          end else if (tick) begin
            cnt_q <= (cnt_q == RepLast) ? '0 : cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          held    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Button event arbiter: ms prescaler, one press_timer per button, pending slots and a
// round-robin arbiter feeding a single registered valid/ready event stream.
module button_event_arbiter
  import clock_shield_pkg::*;
#(
  parameter int unsigned N_BTN     = 4,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_BTN-1:0]       btn_down,
  input  logic [N_BTN-1:0]       btn_up,
  output logic [N_BTN-1:0]       held,
  button_event_arbiter_if.master ev
);
  localparam int unsigned IdxW = $clog2(N_BTN);
  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

  logic [DivW-1:0] pre_q;
  logic            tick;

  assign tick = (pre_q == DivLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + DivW'(1);
  end

  logic [N_BTN-1:0] strobe;
  ev_type_e         strobe_type [N_BTN];

  for (genvar g = 0; g < N_BTN; g++) begin : g_timer
    press_timer #(
      .LONG_MS   (LONG_MS),
      .REPEAT_MS (REPEAT_MS)
    ) u_press_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .down      (btn_down[g]),
      .up        (btn_up[g]),
      .held      (held[g]),
      .ev_strobe (strobe[g]),
      .ev_type   (strobe_type[g])
    );
  end

  logic [N_BTN-1:0] slot_v_q, slot_v_d;
  ev_type_e         slot_t_q [N_BTN];
  ev_type_e         slot_t_d [N_BTN];

  logic            valid_q;
  logic [IdxW-1:0] btn_q;
  ev_type_e        type_q;
  logic [IdxW-1:0] ptr_q, ptr_d;

  logic             load, any;
  logic [IdxW-1:0]  gidx, cand;
  int unsigned      idx;
  logic [N_BTN-1:0] grant;

  assign load = !valid_q || ev.ev_ready;

  // First pending slot at or after the pointer, wrapping modulo N_BTN.
  always_comb begin
    any  = 1'b0;
    gidx = '0;
    idx  = 0;
    cand = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      idx  = (32'(ptr_q) + k) % N_BTN;
      cand = IdxW'(idx);
      if (!any && slot_v_q[cand]) begin
        any  = 1'b1;
        gidx = cand;
      end
    end
    ptr_d = (gidx == IdxW'(N_BTN - 1)) ? '0 : gidx + IdxW'(1);
  end

  // Clear on grant first so a same-cycle write (even a REPEAT) lands in the freed slot.
  always_comb begin
    for (int unsigned i = 0; i < N_BTN; i++) begin
      grant[i]    = load && any && (gidx == IdxW'(i));
      slot_v_d[i] = slot_v_q[i] && !grant[i];
      slot_t_d[i] = slot_t_q[i];
      if (strobe[i] && (strobe_type[i] != EV_REPEAT || !slot_v_d[i])) begin
        slot_v_d[i] = 1'b1;
        slot_t_d[i] = strobe_type[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v_q <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) slot_t_q[i] <= EV_SHORT;
    end else begin
      slot_v_q <= slot_v_d;
      for (int unsigned i = 0; i < N_BTN; i++) slot_t_q[i] <= slot_t_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      btn_q   <= '0;
      type_q  <= EV_SHORT;
      ptr_q   <= '0;
    end else if (load) begin
      valid_q <= any;
      if (any) begin
        btn_q  <= gidx;
        type_q <= slot_t_q[gidx];
        ptr_q  <= ptr_d;
      end
    end
  end

  assign ev.ev_valid = valid_q;
  assign ev.ev_btn   = btn_q;
  assign ev.ev_type  = type_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with TICK_DIV=4, LONG_MS=5, REPEAT_MS=2, N_BTN=4.
module tb_button_event_arbiter;
  import clock_shield_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn_down = '0;
  logic [3:0] btn_up = '0;
  logic [3:0] held;

  button_event_arbiter_if #(.N_BTN(4)) bif ();

  button_event_arbiter #(
    .N_BTN     (4),
    .TICK_DIV  (4),
    .LONG_MS   (5),
    .REPEAT_MS (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_down (btn_down),
    .btn_up   (btn_up),
    .held     (held),
    .ev       (bif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int btn;
    int typ;
  } ev_rec_t;

  ev_rec_t evq[$];
  int      cyc;
  int      tests;
  int      fails;

  // Accepted handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && bif.ev_valid && bif.ev_ready)
      evq.push_back('{cyc, int'(bif.ev_btn), int'(bif.ev_type)});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic pulse(input logic [3:0] dn, input logic [3:0] up);
    btn_down = dn;
    btn_up   = up;
    step();
    btn_down = '0;
    btn_up   = '0;
  endtask

  // Leaves the bench at cycle 0: prescaler at 0, first tick in cycle 3, then every 4 cycles.
  task automatic apply_reset();
    rst_n        = 1'b0;
    btn_down     = '0;
    btn_up       = '0;
    bif.ev_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    cyc   = 0;
    evq.delete();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bif.ev_ready = 1'b1;
    #1;
    tests++; if (bif.ev_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b want 0", bif.ev_valid); end
    tests++; if (bif.ev_btn !== 2'd0) begin fails++; $display("FAIL rst_btn got %0d want 0", bif.ev_btn); end
    tests++; if (bif.ev_type !== 2'd0) begin fails++; $display("FAIL rst_type got %0d want 0", bif.ev_type); end
    tests++; if (held !== 4'b0000) begin fails++; $display("FAIL rst_held got %b want 0000", held); end
    apply_reset();
    run_to(12);
    tests++; if (bif.ev_valid !== 1'b0) begin fails++; $display("FAIL idle_valid got %0b want 0", bif.ev_valid); end
  endtask

  task automatic test_short();
    apply_reset();
    pulse(4'b0010, 4'b0000);
    tests++; if (held !== 4'b0010) begin fails++; $display("FAIL short_held_rise got %b want 0010", held); end
    run_to(12);
    pulse(4'b0000, 4'b0010);
    tests++; if (held !== 4'b0000) begin fails++; $display("FAIL short_held_fall got %b want 0000", held); end
    tests++; if (bif.ev_valid !== 1'b0) begin fails++; $display("FAIL short_early got %0b want 0", bif.ev_valid); end
    step();
    tests++;
    if (bif.ev_valid !== 1'b1 || bif.ev_btn !== 2'd1 || bif.ev_type !== 2'd0) begin
      fails++;
      $display("FAIL short_event got v=%0b btn=%0d type=%0d want v=1 btn=1 type=0",
               bif.ev_valid, bif.ev_btn, bif.ev_type);
    end
    run_to(24);
    tests++; if (evq.size() !== 1) begin fails++; $display("FAIL short_count got %0d want 1", evq.size()); end
  endtask

  task automatic test_long_hold();
    int exp_c[3] = '{21, 29, 37};
    int exp_t[3] = '{1, 2, 2};
    apply_reset();
    pulse(4'b0100, 4'b0000);
    run_to(40);
    tests++; if (held !== 4'b0100) begin fails++; $display("FAIL long_held got %b want 0100", held); end
    pulse(4'b0000, 4'b0100);
    run_to(52);
    tests++; if (evq.size() !== 3) begin fails++; $display("FAIL long_count got %0d want 3", evq.size()); end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (k >= evq.size()) begin
        fails++;
        $display("FAIL long_ev%0d got none want cyc=%0d btn=2 type=%0d", k, exp_c[k], exp_t[k]);
      end else if (evq[k].cyc !== exp_c[k] || evq[k].btn !== 2 || evq[k].typ !== exp_t[k]) begin
        fails++;
        $display("FAIL long_ev%0d got cyc=%0d btn=%0d type=%0d want cyc=%0d btn=2 type=%0d",
                 k, evq[k].cyc, evq[k].btn, evq[k].typ, exp_c[k], exp_t[k]);
      end
    end
  endtask

  task automatic test_simultaneous();
    int exp_c[4] = '{14, 15, 26, 27};
    int exp_b[4] = '{0, 3, 0, 2};
    apply_reset();
    pulse(4'b1001, 4'b0000);
    run_to(12);
    pulse(4'b0000, 4'b1001);
    run_to(20);
    pulse(4'b0101, 4'b0000);
    run_to(24);
    pulse(4'b0000, 4'b0101);
    run_to(34);
    tests++; if (evq.size() !== 4) begin fails++; $display("FAIL simul_count got %0d want 4", evq.size()); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (k >= evq.size()) begin
        fails++;
        $display("FAIL simul_ev%0d got none want cyc=%0d btn=%0d", k, exp_c[k], exp_b[k]);
      end else if (evq[k].cyc !== exp_c[k] || evq[k].btn !== exp_b[k] || evq[k].typ !== 0) begin
        fails++;
        $display("FAIL simul_ev%0d got cyc=%0d btn=%0d type=%0d want cyc=%0d btn=%0d type=0",
                 k, evq[k].cyc, evq[k].btn, evq[k].typ, exp_c[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    bif.ev_ready = 1'b0;
    pulse(4'b0001, 4'b0000);
    run_to(20);
    tests++; if (bif.ev_valid !== 1'b0) begin fails++; $display("FAIL bp_early got %0b want 0", bif.ev_valid); end
    run_to(21);
    tests++;
    if (bif.ev_valid !== 1'b1 || bif.ev_btn !== 2'd0 || bif.ev_type !== 2'd1) begin
      fails++;
      $display("FAIL bp_long got v=%0b btn=%0d type=%0d want v=1 btn=0 type=1",
               bif.ev_valid, bif.ev_btn, bif.ev_type);
    end
    run_to(48);
    pulse(4'b0000, 4'b0001);
    run_to(51);
    tests++;
    if (bif.ev_valid !== 1'b1 || bif.ev_btn !== 2'd0 || bif.ev_type !== 2'd1) begin
      fails++;
      $display("FAIL bp_frozen got v=%0b btn=%0d type=%0d want v=1 btn=0 type=1",
               bif.ev_valid, bif.ev_btn, bif.ev_type);
    end
    run_to(52);
    bif.ev_ready = 1'b1;
    step();
    tests++;
    if (bif.ev_valid !== 1'b1 || bif.ev_btn !== 2'd0 || bif.ev_type !== 2'd2) begin
      fails++;
      $display("FAIL bp_repeat got v=%0b btn=%0d type=%0d want v=1 btn=0 type=2",
               bif.ev_valid, bif.ev_btn, bif.ev_type);
    end
    step();
    tests++; if (bif.ev_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got %0b want 0", bif.ev_valid); end
    run_to(64);
    tests++; if (evq.size() !== 2) begin fails++; $display("FAIL bp_count got %0d want 2", evq.size()); end
  endtask

  task automatic test_coincidence();
    apply_reset();
    pulse(4'b0010, 4'b0000);
    run_to(19);
    pulse(4'b0000, 4'b0010);
    run_to(40);
    tests++; if (evq.size() !== 1) begin fails++; $display("FAIL coin_count got %0d want 1", evq.size()); end
    tests++;
    if (evq.size() < 1) begin
      fails++;
      $display("FAIL coin_ev got none want cyc=21 btn=1 type=0");
    end else if (evq[0].cyc !== 21 || evq[0].btn !== 1 || evq[0].typ !== 0) begin
      fails++;
      $display("FAIL coin_ev got cyc=%0d btn=%0d type=%0d want cyc=21 btn=1 type=0",
               evq[0].cyc, evq[0].btn, evq[0].typ);
    end
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    pulse(4'b1000, 4'b0000);
    run_to(4);
    pulse(4'b0000, 4'b1000);
    run_to(8);
    pulse(4'b0001, 4'b0000);
    run_to(19);
    tests++; if (held !== 4'b0001) begin fails++; $display("FAIL mid_held_pre got %b want 0001", held); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bif.ev_valid !== 1'b0 || bif.ev_btn !== 2'd0 || bif.ev_type !== 2'd0 || held !== 4'b0000) begin
      fails++;
      $display("FAIL mid_rst got v=%0b btn=%0d type=%0d held=%b want all 0",
               bif.ev_valid, bif.ev_btn, bif.ev_type, held);
    end
    step();
    step();
    step();
    rst_n = 1'b1;
    evq.delete();
    run_to(30);
    pulse(4'b0000, 4'b0001);
    run_to(70);
    tests++; if (held !== 4'b0000) begin fails++; $display("FAIL mid_held_post got %b want 0000", held); end
    tests++; if (evq.size() !== 0) begin fails++; $display("FAIL mid_events got %0d want 0", evq.size()); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    bif.ev_ready = 1'b1;
    #2;
    test_reset();
    test_short();
    test_long_hold();
    test_simultaneous();
    test_backpressure();
    test_coincidence();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects the `down`/`up` pulses of up to N per-button debouncers and turns them into classified events: short press, long press and auto-repeat. Arbitrates those events round-robin into a single valid/ready stream. Sits between the debouncer bank and the clock-shield time-setting FSM, so that FSM sees one event at a time and never deals with hold timing.

## Interface
- `N_BTN`, 4, number of buttons (2..8)
- `TICK_DIV`, 50000, clk cycles per ms tick (50 MHz → 1 ms)
- `LONG_MS`, 1000, ticks held before the LONG event (≥2)
- `REPEAT_MS`, 200, ticks between REPEAT events after LONG (≥1)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `btn_down`  in  N_BTN  one-cycle press pulses from debouncers
- `btn_up`  in  N_BTN  one-cycle release pulses from debouncers
- `ev_valid`  out  1  event available
- `ev_ready`  in  1  consumer accepts event when high with `ev_valid`
- `ev_btn`  out  $clog2(N_BTN)  index of the button that raised the event
- `ev_type`  out  2  0=SHORT, 1=LONG, 2=REPEAT (3 never driven)
- `held`  out  N_BTN  per-button pressed state

## Operation
- Prescaler:
  - free-running 0..TICK_DIV-1; `tick` high for one cycle when the count wraps.
- Per-button FSM, states IDLE, HELD, AUTO; each button has a tick counter of width $clog2(LONG_MS+1):
  - IDLE → HELD on `btn_down[i]`; counter cleared; `held[i]` set.
  - HELD:
    - each tick increments the counter.
    - When the counter reaches LONG_MS on a tick: raise LONG, clear the counter, go to AUTO.
    - `btn_up[i]` before that raises SHORT and returns to IDLE.
  - AUTO:
    - each tick increments the counter.
    - When the counter reaches REPEAT_MS: raise REPEAT and clear the counter.
    - `btn_up[i]` returns to IDLE with no event.
  - `btn_up` in IDLE and `btn_down` outside IDLE are ignored.
  - If `btn_down[i]` and `btn_up[i]` arrive in the same cycle, `btn_up` wins.
  - If `btn_up[i]` and a threshold tick coincide in HELD, SHORT wins and no LONG is raised.
- Pending slot, one per button (valid + type):
  - A raised event writes the slot.
  - SHORT and LONG overwrite a pending REPEAT.
  - A REPEAT is dropped if the slot is already valid.
  - SHORT or LONG arriving while SHORT or LONG is pending overwrites it. This is accepted loss; the consumer is required to keep up.
- Arbiter:
  - The output register loads when it is empty, or in the cycle it is consumed (`ev_valid & ev_ready`).
  - Source is the next valid slot at or after the round-robin pointer.
  - The loaded slot clears in the same cycle. The pointer moves to the granted index + 1, modulo N_BTN.
  - A slot written in the same cycle it is granted keeps the new event.
- Output register:
  - `ev_btn`/`ev_type` hold stable while `ev_valid` is high and `ev_ready` is low.

## Timing
- Reset values: `ev_valid`=0, `ev_btn`=0, `ev_type`=0, `held`=0. All FSMs IDLE, slots empty, pointer 0, prescaler 0.
- Reset asserted mid-hold or mid-handshake discards all state. After release, no event is produced until a fresh `btn_down`.
- `held[i]` rises 1 cycle after `btn_down[i]` and falls 1 cycle after `btn_up[i]`.
- Event latency: the slot is written 1 cycle after its cause (pulse or tick). `ev_valid` rises 1 cycle later if the output is free, so 2 cycles minimum.
- Back-to-back throughput: 1 event per cycle with `ev_ready` held high.
- Counters saturate logic-wise: the compare is exact-equal and the counter clears on a match, so no wrap occurs.
- LONG is raised on the LONG_MS-th tick after press; first REPEAT on tick LONG_MS+REPEAT_MS, then every REPEAT_MS ticks.

## Structure
- Shared package `clock_shield_pkg`:
  - `ev_type` enum (EV_SHORT, EV_LONG, EV_REPEAT)
  - per-button state enum
- Sub-module `press_timer`: one per button (generate loop). Contains the FSM and counter, and drives that button's `held` bit and event strobe with its type.
- Top level holds the prescaler, pending slots, round-robin arbiter and output register.

## Test plan
Parameters for all scenarios: TICK_DIV=4, LONG_MS=5, REPEAT_MS=2, N_BTN=4.
- Short press: `btn_down[1]`, `btn_up[1]` 3 ticks later, `ev_ready`=1 → exactly one event, `ev_btn`=1, `ev_type`=0, `ev_valid` high 2 cycles after `btn_up`.
- Long hold: `btn_down[2]` held 10 ticks → LONG at tick 5, REPEAT at ticks 7 and 9, no SHORT on release.
- Simultaneous: `btn_down` and `btn_up` on buttons 0 and 3 with identical timing, pointer at 0 → SHORT(0), then SHORT(3) on consecutive cycles, pointer ends at 0.
- Backpressure: `ev_ready`=0 during a 12-tick hold of button 0 → output frozen on LONG(0), the slot keeps one REPEAT, extra REPEATs dropped. Then `ev_ready`=1 → LONG(0), REPEAT(0), then idle.
- Coincidence: `btn_up[1]` in the same cycle as the 5th tick → SHORT(1) only.
- Reset mid-hold: `rst_n` low for 3 cycles at tick 3 of a hold → all outputs 0. No event after release, even when the stale `btn_up` arrives.
